// File: rtl/led_step_ctrl.sv
// led_step_ctrl -- control stage in front of the 8-bit LED rotator.
//
// This block takes four raw push-buttons and turns them into three things:
//   - a one-cycle `step` strobe at one of four rates,
//   - a direction level, and
//   - a run/pause status.
// The rotator moves one position for each `step` pulse, in place of
// rotating on every clock.
//
// Each button passes through these stages in order:
//   2-flop synchronizer -> counter-based debouncer -> registered press pulse.
// A raw 0->1 edge reaches the control registers exactly DB_CNT+3 edges later.
//
// Ports:
//   clk      in   system clock, all logic on rising edge
//   rst      in   synchronous active-high reset
//   btn_up   in   raw button, raise rate (saturates at 3)
//   btn_dn   in   raw button, lower rate (saturates at 0)
//   btn_dir  in   raw button, toggle direction
//   btn_run  in   raw button, toggle run/pause
//   step     out  registered one-cycle advance strobe
//   dir      out  0 = rotate right, 1 = rotate left
//   running  out  1 = RUN, 0 = PAUSE
//   rate     out  rate index 0..3; step period = BASE_DIV >> rate
module led_step_ctrl #(
  parameter int DB_CNT   = 500000,
  parameter int BASE_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_dir,
  input  logic       btn_run,
  output logic       step,
  output logic       dir,
  output logic       running,
  output logic [1:0] rate
);

  localparam int DB_W = $clog2(DB_CNT + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] BASE    = CNT_W'(BASE_DIV);

  // Bit order: 0 = up, 1 = dn, 2 = dir, 3 = run
  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btn_run, btn_dir, btn_dn, btn_up};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            db_reg;
      logic            press_reg;
      logic [DB_W-1:0] db_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          db_reg     <= 1'b0;
          press_reg  <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == db_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            // DB_CNT-th consecutive differing sample: accept the new level.
            // The press pulse is registered on this same edge, which keeps
            // the overall press latency at DB_CNT+3 edges.
            db_reg     <= sync2_reg;
            db_cnt_reg <= '0;
            press_reg  <= sync2_reg;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  typedef enum logic {S_RUN = 1'b0, S_PAUSE = 1'b1} run_state_t;

  run_state_t       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] period;
  logic [1:0]       rate_reg, rate_next;
  logic             dir_reg, dir_next;
  logic             step_reg, step_next;

  always_comb begin
    period     = BASE >> rate_reg;
    rate_next  = rate_reg;
    dir_next   = dir_reg ^ press[2];
    state_next = state_reg;
    count_next = count_reg;
    step_next  = 1'b0;

    // Opposing presses in the same cycle cancel out.
    if (press[0] && !press[1] && rate_reg != 2'd3) begin
      rate_next = rate_reg + 2'd1;
    end else if (press[1] && !press[0] && rate_reg != 2'd0) begin
      rate_next = rate_reg - 2'd1;
    end

    if (press[3]) begin
      state_next = (state_reg == S_RUN) ? S_PAUSE : S_RUN;
    end

    // A real rate change restarts the period and suppresses any wrap this
    // cycle. The run state is judged on its current value, so a wrap that
    // coincides with a pause press still emits its step.
    if (rate_next != rate_reg) begin
      count_next = '0;
    end else if (state_reg == S_RUN) begin
      if (count_reg == period - CNT_W'(1)) begin
        count_next = '0;
        step_next  = 1'b1;
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_RUN;
      count_reg <= '0;
      rate_reg  <= 2'd0;
      dir_reg   <= 1'b0;
      step_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      rate_reg  <= rate_next;
      dir_reg   <= dir_next;
      step_reg  <= step_next;
    end
  end

  assign step    = step_reg;
  assign dir     = dir_reg;
  assign running = (state_reg == S_RUN);
  assign rate    = rate_reg;

endmodule

// File: tb/tb_led_step_ctrl.sv
// tb_led_step_ctrl -- self-checking bench for led_step_ctrl.
//
// The reference model tracks absolute edge numbers:
//   - when the next step is due while running,
//   - how many edges remain while paused,
//   - and, per button, the edge at which its press takes effect.
// Every edge is compared against the DUT outputs step, dir, running and rate.
module tb_led_step_ctrl;

  localparam int DB   = 4;
  localparam int BASE = 16;
  localparam int CW   = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       step;
  logic       dir;
  logic       running;
  logic [1:0] rate;

  led_step_ctrl #(
    .DB_CNT  (DB),
    .BASE_DIV(BASE),
    .CNT_W   (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_up (btn[0]),
    .btn_dn (btn[1]),
    .btn_dir(btn[2]),
    .btn_run(btn[3]),
    .step   (step),
    .dir    (dir),
    .running(running),
    .rate   (rate)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int t        = 0;   // number of rising edges seen so far

  // Reference model state
  int m_rate;
  int m_dir;
  int m_run;
  int m_step;
  int m_next;         // edge at which the next step is due (RUN)
  int m_rem;          // edges still to go once resumed (PAUSE)
  int pend_at [4];    // edge at which a press takes effect, -1 = none

  function automatic int per(input int r);
    return BASE >> r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    int pr [4];
    int new_rate;
    int chg;

    if (rst) begin
      m_rate = 0;
      m_dir  = 0;
      m_run  = 1;
      m_step = 0;
      m_next = t + BASE;
      m_rem  = BASE;
      for (int b = 0; b < 4; b++) pend_at[b] = -1;
      return;
    end

    for (int b = 0; b < 4; b++) begin
      pr[b] = (pend_at[b] == t) ? 1 : 0;
      if (pr[b] != 0) pend_at[b] = -1;
    end

    new_rate = m_rate;
    if (pr[0] != 0 && pr[1] == 0) begin
      new_rate = (m_rate == 3) ? 3 : m_rate + 1;
    end else if (pr[1] != 0 && pr[0] == 0) begin
      new_rate = (m_rate == 0) ? 0 : m_rate - 1;
    end
    chg = (new_rate != m_rate) ? 1 : 0;

    m_step = (m_run != 0 && t == m_next && chg == 0) ? 1 : 0;
    if (m_step != 0) m_next = t + per(m_rate);
    if (chg != 0) begin
      m_next = t + per(new_rate);
      m_rem  = per(new_rate);
    end
    m_rate = new_rate;

    if (pr[2] != 0) m_dir = 1 - m_dir;

    if (pr[3] != 0) begin
      if (m_run != 0) begin
        m_rem = m_next - t;
        m_run = 0;
      end else begin
        m_next = t + m_rem;
        m_run  = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    model_edge();
    #1;
    chk("step",    {7'd0, step},    8'(m_step));
    chk("dir",     {7'd0, dir},     8'(m_dir));
    chk("running", {7'd0, running}, 8'(m_run));
    chk("rate",    {6'd0, rate},    8'(m_rate));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    $display("reset cycles=%0d edge=%0d", n, t);
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    btn = btn | mask;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) pend_at[b] = t + DB + 3;
    end
    $display("press mask=%b hold=%0d gap=%0d edge=%0d", mask, hold, gap, t);
    repeat (hold) tick();
    btn = btn & ~mask;
    repeat (gap) tick();
  endtask

  task automatic glitch(input logic [3:0] mask, input int len);
    btn = btn | mask;
    $display("glitch mask=%b len=%0d edge=%0d", mask, len, t);
    repeat (len) tick();
    btn = btn & ~mask;
    repeat (12) tick();
  endtask

  initial begin
    int op;

    rst = 1'b1;
    btn = 4'b0000;
    m_rate = 0; m_dir = 0; m_run = 1; m_step = 0;
    m_next = BASE; m_rem = BASE;
    for (int b = 0; b < 4; b++) pend_at[b] = -1;

    // 1: reset, then free-running steps at rate 0
    do_reset(3);
    repeat (50) tick();

    // 2: rate up to saturation, then one more press at the limit
    press(4'b0001, 20, 30);
    for (int i = 0; i < 4; i++) press(4'b0001, 10, 20);
    press(4'b0001, 8, 20);

    // 3: short glitch on dn, then up and dn together
    glitch(4'b0010, 3);
    repeat (10) tick();
    press(4'b0011, 10, 30);

    // 4: back to rate 0, pause for 100 cycles, then resume
    for (int i = 0; i < 3; i++) press(4'b0010, 8, 20);
    repeat (5) tick();
    press(4'b1000, 8, 100);
    press(4'b1000, 8, 40);

    // 5: direction toggled twice
    press(4'b0100, 8, 40);
    press(4'b0100, 8, 40);

    // 6: reset while paused at rate 2 / dir 1 with up mid-debounce
    press(4'b0001, 8, 20);
    press(4'b0001, 8, 20);
    press(4'b0100, 8, 20);
    press(4'b1000, 8, 20);
    btn[0] = 1'b1;
    pend_at[0] = t + DB + 3;
    repeat (3) tick();
    btn[0] = 1'b0;
    do_reset(3);
    repeat (40) tick();

    // Randomized phase
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        press(4'($urandom_range(1, 15)), int'($urandom_range(6, 20)), int'($urandom_range(10, 30)));
      end else if (op <= 7) begin
        glitch(4'($urandom_range(1, 15)), int'($urandom_range(1, DB - 1)));
      end else if (op == 8) begin
        repeat (int'($urandom_range(1, 40))) tick();
      end else begin
        do_reset(int'($urandom_range(1, 3)));
        repeat (5) tick();
      end
    end
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
